// File: rtl/psx_valu.sv
// Packed-SIMD vector ALU: two-stage lane pipeline feeding an in-order result FIFO
// with a valid/ready writeback port and one reserved slot for a late-issued op.
module psx_valu #(
  parameter int DEPTH = 4
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_ni,
  input  logic        flush_i,
  input  logic [31:0] valu_a,
  input  logic [31:0] valu_b,
  input  logic [6:0]  valu_opc,
  input  logic [4:0]  valu_rob_id,
  input  logic [5:0]  valu_dest,
  input  logic        valu_valid,
  output logic        ready_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rob_o,
  output logic [5:0]  wb_dest_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 + 5 + 6;
  localparam logic [CW:0] LIM_READY = (CW+1)'(DEPTH - 2);
  localparam logic [CW:0] LIM_FULL  = (CW+1)'(DEPTH);

  function automatic logic [31:0] f_lane_op(input logic [2:0] opc,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic [8:0]  s;
    r = 32'h0000_0000;
    s = 9'h000;
    case (opc)
      3'b000: for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
      3'b001: for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] - b[8*i +: 8];
      3'b010: for (int i = 0; i < 2; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
      3'b011: for (int i = 0; i < 2; i++) r[16*i +: 16] = a[16*i +: 16] - b[16*i +: 16];
      3'b100: begin
        for (int i = 0; i < 4; i++) begin
          s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
          r[8*i +: 8] = s[8] ? 8'hFF : s[7:0];
        end
      end
      3'b101: begin
        for (int i = 0; i < 4; i++)
          r[8*i +: 8] = (a[8*i +: 8] >= b[8*i +: 8]) ? (a[8*i +: 8] - b[8*i +: 8]) : 8'h00;
      end
      3'b110: begin
        for (int i = 0; i < 4; i++)
          r[8*i +: 8] = (a[8*i +: 8] >= b[8*i +: 8]) ? a[8*i +: 8] : b[8*i +: 8];
      end
      3'b111: begin
        for (int i = 0; i < 4; i++)
          r[8*i +: 8] = (a[8*i +: 8] <= b[8*i +: 8]) ? a[8*i +: 8] : b[8*i +: 8];
      end
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic          r_s1_valid;
  logic [31:0]   r_s1_a;
  logic [31:0]   r_s1_b;
  logic [2:0]    r_s1_opc;
  logic [4:0]    r_s1_rob;
  logic [5:0]    r_s1_dest;
  logic          r_s2_valid;
  logic [31:0]   r_s2_data;
  logic [4:0]    r_s2_rob;
  logic [5:0]    r_s2_dest;
  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [CW:0]   w_sum;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_opc;

  // Every accepted op owns a FIFO slot from acceptance on, so the occupancy
  // sum can never exceed DEPTH and S2 never meets a full FIFO without a pop.
  assign w_sum    = {1'b0, r_count} + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
  assign w_accept = valu_valid & ~flush_i & (w_sum < LIM_FULL);
  assign w_push   = r_s2_valid & ~flush_i;
  assign w_pop    = wb_valid_o & wb_ready_i & ~flush_i;

  assign w_unused_opc = ^valu_opc[6:3];

  assign ready_o    = (w_sum <= LIM_READY);
  assign wb_valid_o = (r_count != {CW{1'b0}});
  assign {wb_data_o, wb_rob_o, wb_dest_o} = r_mem[r_rptr];

  // Control state: stage valids, FIFO pointers and occupancy.
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_wptr     <= {PW{1'b0}};
      r_rptr     <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Datapath and FIFO storage carry no reset; validity lives in the control state.
  always_ff @(posedge cpu_clock_i) begin
    if (w_accept) begin
      r_s1_a    <= valu_a;
      r_s1_b    <= valu_b;
      r_s1_opc  <= valu_opc[2:0];
      r_s1_rob  <= valu_rob_id;
      r_s1_dest <= valu_dest;
    end
    r_s2_data <= f_lane_op(r_s1_opc, r_s1_a, r_s1_b);
    r_s2_rob  <= r_s1_rob;
    r_s2_dest <= r_s1_dest;
    if (w_push) r_mem[r_wptr] <= {r_s2_data, r_s2_rob, r_s2_dest};
  end

endmodule

// File: doc/psx_valu.md
PSX_VALU -- requirements
Module: psx_valu

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entry count (power of two, >=4).
REQ-002 SHALL have port cpu_clock_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port cpu_reset_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  in  1  pipeline flush, kills all in-flight and buffered ops.
REQ-005 SHALL have ports valu_a, valu_b  in  32 each  packed operands.
REQ-006 SHALL have port valu_opc  in  7  operation; only [2:0] decoded, [6:3] ignored.
REQ-007 SHALL have ports valu_rob_id  in  5  ROB tag, and valu_dest  in  6  physical destination.
REQ-008 SHALL have port valu_valid  in  1  one op offered this cycle, no handshake back.
REQ-009 SHALL have port ready_o  out  1  issue permission for the next op.
REQ-010 SHALL have ports wb_data_o  out  32, wb_rob_o  out  5, wb_dest_o  out  6  FIFO head result.
REQ-011 SHALL have ports wb_valid_o  out  1 and wb_ready_i  in  1  writeback valid/ready pair.

Function
REQ-012 SHALL decode opc[2:0]: 000 add8, 001 sub8, 010 add16, 011 sub16, 100 unsigned saturating add8, 101 unsigned saturating sub8, 110 maxu8, 111 minu8.
REQ-013 SHALL treat lanes independently: 8-bit ops use 4 lanes, 16-bit ops 2 lanes, modulo-2^n wrap except saturating ops (clamp 0xFF / 0x00).
REQ-014 SHALL accept an op at edge E0 when valu_valid=1 and flush_i=0, capturing operands, opc, tag, dest into stage S1.
REQ-015 SHALL compute lane results S1->S2 at E1 and write S2 into the FIFO at E2; wb_valid_o rises after E2 when the FIFO was empty (latency 3 edges).
REQ-016 SHALL keep results in acceptance order; tag and dest travel unchanged with data.
REQ-017 SHALL assert wb_valid_o exactly when FIFO count != 0; head pops on an edge with wb_valid_o=1 and wb_ready_i=1.
REQ-018 SHALL hold wb_data_o/wb_rob_o/wb_dest_o stable while wb_valid_o=1 and wb_ready_i=0.
REQ-019 SHALL support push and pop on the same edge, count unchanged, including count=DEPTH with pop.
REQ-020 SHALL drive ready_o = (count + S1valid + S2valid) <= DEPTH-2, reserving one slot for an op already registered upstream.
REQ-021 SHALL, on flush_i=1 at an edge, clear S1/S2 valid and set count, read and write pointers to 0; a coincident valu_valid or wb pop is discarded.
REQ-022 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-023 SHALL ignore valu_valid when the FIFO would overflow, and the bench SHALL flag it as a protocol violation assertion.

Reset
REQ-024 SHALL, while cpu_reset_ni=0, force S1/S2 valid=0, count=0, pointers=0, wb_valid_o=0, ready_o=1, regardless of clock.
REQ-025 SHALL leave datapath registers and FIFO storage unreset; wb_data_o is don't-care while wb_valid_o=0.
REQ-026 SHALL resume accepting ops on the first rising edge after cpu_reset_ni deasserts, including mid-operation reset.

Verification
REQ-027 add8 a=0x01FF7F80, b=0x01010101, rob=3, dest=9, wb_ready_i=1 -> wb_valid_o after 3 edges, wb_data_o=0x02008081, wb_rob_o=3, wb_dest_o=9.
REQ-028 addsat8 a=0xF0FF1000, b=0x20010F00 -> 0xFFFF1F00; subsat8 a=0x10000505, b=0x20010306 -> 0x00000200; sub16 a=0x00000005, b=0x00010006 -> 0xFFFFFFFF.
REQ-029 wb_ready_i=0, issue while ready_o=1 -> ready_o falls when count+inflight=3 (DEPTH=4), 4 results buffered, release wb_ready_i -> 4 results in order, one per cycle.
REQ-030 Push and pop same edge at count=4 -> count stays 4, order preserved across pointer wrap.
REQ-031 flush_i with 2 in flight, 3 buffered, valu_valid=1 -> next cycle wb_valid_o=0, ready_o=1, none of those tags ever appear.
REQ-032 cpu_reset_ni low mid-stream, no clock edge -> wb_valid_o=0 and ready_o=1 immediately; after release a new maxu8 a=0x80017F00, b=0x7F02FF01 -> 0x8002FF01.
